mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, 32, address and data width in bits.
REQ-002 Parameter TIMEOUT, 64, maximum memory wait cycles before the error flag sets.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 IReq  in  1  fetch stage requests an instruction word.
REQ-006 IAddr  in  WIDTH  fetch address (PCF).
REQ-007 DReq  in  1  MEM stage requests a load or store.
REQ-008 DWe  in  1  1 = store, 0 = load.
REQ-009 DAddr  in  WIDTH  data address (ALUResultM).
REQ-010 DWData  in  WIDTH  store data (WriteDataM).
REQ-011 IRData, DRData  out  WIDTH each  registered read data for fetch and MEM.
REQ-012 IDone, DDone  out  1 each  one-cycle completion pulse per port.
REQ-013 StallI, StallD  out  1 each  pipeline freeze requests for the fetch and MEM sides.
REQ-014 mem_req, mem_we  out  1 each  single-port memory request and write enable.
REQ-015 mem_addr, mem_wdata  out  WIDTH each  memory address and write data.
REQ-016 mem_ready  in  1  memory completes the current access this cycle.
REQ-017 mem_rdata  in  WIDTH  read data, valid when mem_ready=1.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have three states: IDLE, IBUSY, DBUSY.
REQ-020 IDLE, only DReq=1: go to DBUSY; latch DAddr, DWData and DWe.
REQ-021 IDLE, only IReq=1: go to IBUSY; latch IAddr; mem_we=0.
REQ-022 IDLE, both requests: grant D unless the previous grant was D, then grant I (alternating); lastgrant reg resets to I.
REQ-023 In IBUSY/DBUSY, mem_req=1; mem_addr, mem_wdata and mem_we SHALL come from the latches and stay stable until mem_ready.
REQ-024 In IDLE, mem_req=0 and mem_we=0.
REQ-025 On mem_ready in IBUSY: IRData<=mem_rdata, IDone pulses next cycle, return to IDLE.
REQ-026 On mem_ready in DBUSY: DRData<=mem_rdata on loads (held on stores), DDone pulses next cycle, return to IDLE.
REQ-027 A new grant SHALL NOT occur in the cycle IDone or DDone is asserted, giving a minimum 3-cycle period per access.
REQ-028 StallI = IReq & ~IDone; StallD = DReq & ~DDone (combinational).
REQ-029 Requesters SHALL hold Req and operands until their Done; a Req dropped mid-access is ignored and the access completes.
REQ-030 A wait counter SHALL clear on each grant and increment each busy cycle without mem_ready.
REQ-031 When the wait counter reaches TIMEOUT: set err, abort to IDLE without a Done pulse, and clear the counter.
REQ-032 mem_ready in IDLE SHALL be ignored.

Reset
REQ-033 rst=1 at posedge: state=IDLE, lastgrant=I, counter=0, err=0, IRData=DRData=0, IDone=DDone=0.
REQ-034 Reset during IBUSY/DBUSY SHALL abandon the access; mem_req is 0 from the next cycle; no Done pulse.
REQ-035 Only rst clears err.

Structure
REQ-036 The FSM state encoding and the TIMEOUT default SHALL be in the shared pipeline package.
REQ-037 The wait counter SHALL be one sub-module, wait_timer (clear, enable, expired).

Verification
REQ-038 DReq=1, DWe=0, DAddr=0x100, mem_ready after 2 cycles with rdata 0xDEADBEEF -> mem_addr=0x100 held; DRData=0xDEADBEEF; DDone pulses once; StallD low after the pulse.
REQ-039 IReq and DReq both held continuously -> grants alternate D, I, D, I; no port is starved.
REQ-040 Store DWData=0x12345678 -> mem_we=1, mem_wdata=0x12345678 for the whole busy period; DRData unchanged.
REQ-041 mem_ready held low for 64 busy cycles -> err=1, state IDLE, no Done; err remains until rst.
REQ-042 rst asserted in the 2nd cycle of IBUSY -> mem_req=0 next cycle; all outputs at reset values; no IDone.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    localparam int WIDTH_DEFAULT   = 32;
    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// Counts busy cycles without mem_ready; expired fires on the cycle the count reaches TIMEOUT.
module wait_timer
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Combinational so the owner can abort in the same cycle the limit is hit.
    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and MEM-stage accesses onto one single-port memory with
// alternating priority, registered read data, Done pulses and a sticky timeout error.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IReq,
    input  logic [WIDTH-1:0] IAddr,
    input  logic             DReq,
    input  logic             DWe,
    input  logic [WIDTH-1:0] DAddr,
    input  logic [WIDTH-1:0] DWData,
    output logic [WIDTH-1:0] IRData,
    output logic [WIDTH-1:0] DRData,
    output logic             IDone,
    output logic             DDone,
    output logic             StallI,
    output logic             StallD,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             err
);

    state_e           state_q, state_d;
    grant_e           last_q, last_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] irdata_q, irdata_d;
    logic [WIDTH-1:0] drdata_q, drdata_d;
    logic             we_q, we_d;
    logic             idone_q, idone_d;
    logic             ddone_q, ddone_d;
    logic             err_q, err_d;
    logic             busy, grant, expired;

    assign busy = (state_q != ST_IDLE);

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant),
        .enable  (busy & ~mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        err_d    = err_q;
        idone_d  = 1'b0;
        ddone_d  = 1'b0;
        grant    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // No grant while a Done is visible, so the requester can drop or renew its Req.
                if (!idone_q && !ddone_q) begin
                    if (DReq && (!IReq || last_q == GNT_I)) begin
                        state_d = ST_DBUSY;
                        addr_d  = DAddr;
                        wdata_d = DWData;
                        we_d    = DWe;
                        last_d  = GNT_D;
                        grant   = 1'b1;
                    end else if (IReq) begin
                        state_d = ST_IBUSY;
                        addr_d  = IAddr;
                        we_d    = 1'b0;
                        last_d  = GNT_I;
                        grant   = 1'b1;
                    end
                end
            end
            ST_IBUSY: begin
                if (mem_ready) begin
                    irdata_d = mem_rdata;
                    idone_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DBUSY: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        drdata_d = mem_rdata;
                    end
                    ddone_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= GNT_I;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            irdata_q <= '0;
            drdata_q <= '0;
            idone_q  <= 1'b0;
            ddone_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            idone_q  <= idone_d;
            ddone_q  <= ddone_d;
            err_q    <= err_d;
        end
    end

    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign IRData    = irdata_q;
    assign DRData    = drdata_q;
    assign IDone     = idone_q;
    assign DDone     = ddone_q;
    assign err       = err_q;
    assign StallI    = IReq & ~idone_q;
    assign StallD    = DReq & ~ddone_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: load, store, alternation, timeout and mid-access reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        IReq, DReq, DWe, mem_ready;
    logic [31:0] IAddr, DAddr, DWData, mem_rdata;
    logic [31:0] IRData, DRData, mem_addr, mem_wdata;
    logic        IDone, DDone, StallI, StallD, mem_req, mem_we, err;

    int n_chk  = 0;
    int n_pass = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .IReq      (IReq),
        .IAddr     (IAddr),
        .DReq      (DReq),
        .DWe       (DWe),
        .DAddr     (DAddr),
        .DWData    (DWData),
        .IRData    (IRData),
        .DRData    (DRData),
        .IDone     (IDone),
        .DDone     (DDone),
        .StallI    (StallI),
        .StallD    (StallD),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_ir, exp_dr;
        logic        want_d;

        IReq = 0; IAddr = 0; DReq = 0; DWe = 0; DAddr = 0; DWData = 0;
        mem_ready = 0; mem_rdata = 0;
        do_reset();

        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we",  32'(mem_we),  32'd0);
        chk("rst_idone",   32'(IDone),   32'd0);
        chk("rst_ddone",   32'(DDone),   32'd0);
        chk("rst_irdata",  IRData,       32'd0);
        chk("rst_drdata",  DRData,       32'd0);
        chk("rst_err",     32'(err),     32'd0);

        // mem_ready while idle must have no effect
        mem_ready = 1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ready = 0;
        tick();
        chk("idle_ready_idone", 32'(IDone), 32'd0);
        chk("idle_ready_ddone", 32'(DDone), 32'd0);
        chk("idle_ready_req",   32'(mem_req), 32'd0);

        // Load: ready on the 2nd busy cycle
        DReq = 1; DWe = 0; DAddr = 32'h100;
        #1;
        chk("ld_stalld_pre", 32'(StallD), 32'd1);
        tick();
        chk("ld_req_b1",  32'(mem_req), 32'd1);
        chk("ld_addr_b1", mem_addr, 32'h100);
        chk("ld_we_b1",   32'(mem_we), 32'd0);
        tick();
        chk("ld_addr_b2", mem_addr, 32'h100);
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 0;
        chk("ld_ddone",   32'(DDone), 32'd1);
        chk("ld_drdata",  DRData, 32'hDEAD_BEEF);
        chk("ld_stalld",  32'(StallD), 32'd0);
        chk("ld_req_off", 32'(mem_req), 32'd0);
        DReq = 0;
        tick();
        chk("ld_ddone_once", 32'(DDone), 32'd0);

        // Store: operands latched, DRData held
        DReq = 1; DWe = 1; DAddr = 32'h200; DWData = 32'h1234_5678;
        tick();
        chk("st_we_b1",    32'(mem_we), 32'd1);
        chk("st_wdata_b1", mem_wdata, 32'h1234_5678);
        chk("st_addr_b1",  mem_addr, 32'h200);
        DWData = 32'hFFFF_0000; DAddr = 32'h999;
        tick();
        chk("st_we_b2",    32'(mem_we), 32'd1);
        chk("st_wdata_b2", mem_wdata, 32'h1234_5678);
        chk("st_addr_b2",  mem_addr, 32'h200);
        mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ready = 0;
        chk("st_ddone",  32'(DDone), 32'd1);
        chk("st_drdata", DRData, 32'hDEAD_BEEF);
        chk("st_we_off", 32'(mem_we), 32'd0);
        DReq = 0; DWe = 0;
        tick();

        // Both requesting continuously: D, I, D, I from reset
        do_reset();
        IReq = 1; IAddr = 32'h40; DReq = 1; DWe = 0; DAddr = 32'h300;
        exp_ir = 0; exp_dr = 0;
        for (int k = 0; k < 4; k++) begin
            want_d = (k % 2 == 0);
            tick();
            chk($sformatf("alt%0d_req", k),  32'(mem_req), 32'd1);
            chk($sformatf("alt%0d_addr", k), mem_addr, want_d ? 32'h300 : 32'h40);
            chk($sformatf("alt%0d_stall", k), 32'(want_d ? StallI : StallD), 32'd1);
            mem_ready = 1; mem_rdata = 32'hA000_0000 + 32'(k);
            if (want_d) exp_dr = mem_rdata; else exp_ir = mem_rdata;
            tick();
            mem_ready = 0;
            chk($sformatf("alt%0d_ddone", k), 32'(DDone), 32'(want_d));
            chk($sformatf("alt%0d_idone", k), 32'(IDone), 32'(!want_d));
            chk($sformatf("alt%0d_irdata", k), IRData, exp_ir);
            chk($sformatf("alt%0d_drdata", k), DRData, exp_dr);
            tick();
            chk($sformatf("alt%0d_gap", k), 32'(mem_req), 32'd0);
        end
        IReq = 0; DReq = 0;

        // Timeout: 64 busy cycles without ready; dropped IReq is ignored
        IReq = 1; IAddr = 32'h80;
        tick();
        IReq = 0;
        for (int c = 0; c < 63; c++) tick();
        chk("to_busy64_req", 32'(mem_req), 32'd1);
        chk("to_busy64_err", 32'(err), 32'd0);
        chk("to_busy64_addr", mem_addr, 32'h80);
        tick();
        chk("to_err",   32'(err), 32'd1);
        chk("to_idle",  32'(mem_req), 32'd0);
        chk("to_idone", 32'(IDone), 32'd0);
        tick();
        tick();
        chk("to_err_sticky", 32'(err), 32'd1);
        chk("to_no_done",    32'(IDone), 32'd0);

        // Reset in the 2nd cycle of IBUSY
        IReq = 1; IAddr = 32'h44;
        tick();
        chk("rb_req_b1", 32'(mem_req), 32'd1);
        tick();
        rst = 1;
        tick();
        rst = 0; IReq = 0;
        chk("rb_req",    32'(mem_req), 32'd0);
        chk("rb_err",    32'(err), 32'd0);
        chk("rb_idone",  32'(IDone), 32'd0);
        chk("rb_irdata", IRData, 32'd0);
        chk("rb_drdata", DRData, 32'd0);
        tick();
        chk("rb_no_done", 32'(IDone), 32'd0);
        chk("rb_idle",    32'(mem_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
